marie_fetch_unit: RTL and testbench
===================================

// Module: marie_fetch_unit
// PURPOSE
//  Instruction fetch stage that sits directly upstream of the MARIE core.
//  - Reads 16-bit instruction words from an external program memory over a req/ack handshake.
//  - Buffers them in a small prefetch FIFO and presents them as {literal[15:8], opcode[7:0]} with a valid/ready pair.
//  - A redirect input flushes the buffer and restarts fetch at a new address.
// PARAMETERS
//  AW          8      fetch address width
//  DW          16     instruction word width ([15:8] literal, [7:0] opcode)
//  DEPTH       4      prefetch FIFO entries; power of 2, >= 2
//  RESET_ADDR  8'h00  first fetch address after reset
// PORTS
//  clk         in   1      single clock; all logic on posedge
//  rst         in   1      asynchronous, active-high reset
//  mem_req     out  1      memory read request
//  mem_addr    out  AW     read address; stable while mem_req=1
//  mem_ack     in   1      one-cycle pulse: mem_rdata valid this cycle
//  mem_rdata   in   DW     read data
//  instr_vld   out  1      instr_data/instr_addr hold a valid word
//  instr_rdy   in   1      consumer accepts head word when instr_vld=1
//  instr_data  out  DW     head instruction word
//  instr_addr  out  AW     address the head word was fetched from
//  redir_vld   in   1      redirect request (one cycle)
//  redir_addr  in   AW     new fetch address
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - mem_req=0, mem_addr=0, instr_vld=0, instr_data=0, instr_addr=0.
//   - FIFO count=0, fetch pointer=RESET_ADDR, FSM=IDLE.
//  FSM states:
//   - IDLE: issue condition is (count + 0) < DEPTH. When true, assert mem_req with mem_addr=fetch ptr next cycle; go to WAIT.
//   - WAIT: hold mem_req/mem_addr until mem_ack.
//     - On ack: push {mem_rdata, mem_addr} and increment fetch ptr.
//     - If space still remains after the push, re-issue back-to-back at the new address (stay WAIT); otherwise go to IDLE with mem_req=0.
//   - FLUSH: entered on redirect while WAIT.
//     - mem_req stays high (the protocol forbids abandoning a request).
//     - The ack data is discarded.
//     - Next cycle, issue at redir_addr and go to WAIT.
//  Space accounting: issue is permitted only when count + outstanding(0/1) < DEPTH, so an ack never finds the FIFO full.
//  Latency: ack in cycle N -> instr_vld=1 in cycle N+1, provided the FIFO was empty.
//  First mem_req is asserted in the first clock edge after rst deasserts.
//  Pop: instr_vld & instr_rdy at the edge removes the head word.
//   - Simultaneous push and pop leaves count unchanged.
//   - Order is strictly FIFO; the ptr/count implementation is free.
//  Redirect (redir_vld=1 at the edge):
//   - Count is set to 0, so instr_vld=0 next cycle; any same-cycle pop is void.
//   - Fetch ptr is set to redir_addr.
//   - IDLE or same-cycle ack in WAIT: that ack's data is dropped. Next request uses redir_addr.
//   - WAIT without ack: go to FLUSH.
//   - A second redirect during FLUSH overwrites the target address; last one wins.
//  Fetch pointer wraps 2^AW-1 -> 0 with no flag.
//  instr_addr is the address of each word, carried through the FIFO alongside the data.
//  Reset mid-transaction: mem_req drops immediately; any later ack is ignored.
//  mem_ack while mem_req=0: ignored.
// STRUCTURE
//  - marie_pkg:
//    - fetch_state_t enum {IDLE, WAIT, FLUSH}
//    - MARIE_AW=8, MARIE_DW=16
//    - LIT_MSB/LIT_LSB/OPC_MSB/OPC_LSB field constants, shared with the core
//  - Sub-module marie_prefetch_fifo: DEPTH x (DW+AW) storage, push/pop/flush, count, registered head outputs.
//  - Top level holds the FSM, the fetch pointer and the space accounting.
// TESTING
//  1 Reset, then ack each req after 1 cycle with rdata=addr*3, instr_rdy=1
//    -> mem_addr 00,01,02..; instr_data 0000,0003,0006 in order, each one cycle after its ack.
//  2 instr_rdy=0, immediate acks -> exactly 4 words buffered; mem_req=0 after the 4th ack.
//    Then 1 pop -> exactly one new req.
//  3 Redirect to 8'h40 while WAIT (ack delayed 3 cycles)
//    -> instr_vld=0; delayed ack data not delivered; next mem_addr=40; first word has instr_addr=40.
//  4 redir_vld together with mem_ack and instr_rdy -> acked word and head both discarded; fetch resumes at redir_addr.
//  5 Redirect to 8'hFE, free-running acks -> instr_addr FE,FF,00,01 (wrap).
//  6 Assert rst during WAIT with 2 words buffered
//    -> mem_req/instr_vld drop the same cycle; after release, fetch restarts at RESET_ADDR; stray ack ignored.

Source files
------------

// File: rtl/marie_pkg.sv
// Shared MARIE definitions: address/data widths, instruction field positions
// and the fetch-unit FSM encoding.
package marie_pkg;

    localparam int MARIE_AW = 8;
    localparam int MARIE_DW = 16;

    localparam int LIT_MSB = 15;
    localparam int LIT_LSB = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/marie_prefetch_fifo.sv
// Prefetch buffer: DEPTH entries of {data, addr}, registered head word,
// single-cycle flush that discards everything including a same-cycle push/pop.
module marie_prefetch_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_vld,
    output logic [W-1:0]           o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_vld;
    logic [W-1:0]  r_head;

    logic          w_pop;
    logic          w_push;
    logic [PW-1:0] w_rd_nxt;
    logic [CW-1:0] w_count_pop;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        w_pop       = i_pop & (r_count != '0) & ~i_flush;
        w_push      = i_push & ~i_flush;
        w_rd_nxt    = r_rd + PW'(w_pop);
        w_count_pop = r_count - CW'(w_pop);
        w_count_nxt = w_count_pop + CW'(w_push);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // A push into an otherwise-empty buffer bypasses storage so the word is
    // presented on the head registers the cycle after it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_vld   <= 1'b0;
            r_head  <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_vld   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_vld   <= (w_count_nxt != '0);
            if (w_push && (w_count_pop == '0)) begin
                r_head <= i_data;
            end else if (w_count_nxt != '0) begin
                r_head <= r_mem[w_rd_nxt];
            end
        end
    end

    assign o_count = r_count;
    assign o_vld   = r_vld;
    assign o_head  = r_head;

endmodule

// File: rtl/marie_fetch_unit.sv
// MARIE instruction fetch: req/ack memory reader feeding a prefetch FIFO,
// with redirect/flush. At most one memory request is outstanding at a time.
module marie_fetch_unit
    import marie_pkg::*;
#(
    parameter int            AW         = MARIE_AW,
    parameter int            DW         = MARIE_DW,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_vld,
    input  logic          instr_rdy,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_addr,
    input  logic          redir_vld,
    input  logic [AW-1:0] redir_addr,
    output fetch_state_t  o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic          r_mem_req;
    logic          w_req_nxt;
    logic [AW-1:0] r_mem_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_after;
    logic [DW+AW-1:0] w_head;

    // Handshakes: a memory transfer completes on a cycle with mem_req & mem_ack
    // (mem_addr frozen while mem_req is high); an instruction is consumed on a
    // cycle with instr_vld & instr_rdy, unless redir_vld voids it.
    assign w_ack = mem_ack & r_mem_req;
    assign w_pop = instr_vld & instr_rdy & ~redir_vld;
    assign w_cnt_after = w_count + CW'(1) - CW'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_mem_req;
        w_addr_nxt  = r_mem_addr;
        w_ptr_nxt   = r_ptr;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (redir_vld) begin
                    w_ptr_nxt   = redir_addr;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = redir_addr;
                    w_state_nxt = WAIT;
                end else if (w_count < DEPTH_C) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_ptr;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redir_vld) begin
                    w_ptr_nxt = redir_addr;
                    if (w_ack) begin
                        w_addr_nxt = redir_addr;
                    end else begin
                        w_state_nxt = FLUSH;
                    end
                end else if (w_ack) begin
                    w_push    = 1'b1;
                    w_ptr_nxt = r_ptr + AW'(1);
                    if (w_cnt_after < DEPTH_C) begin
                        w_addr_nxt = r_ptr + AW'(1);
                    end else begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (redir_vld) begin
                    w_ptr_nxt = redir_addr;
                end
                if (w_ack) begin
                    w_addr_nxt  = redir_vld ? redir_addr : r_ptr;
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_ptr      <= RESET_ADDR;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_req_nxt;
            r_mem_addr <= w_addr_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    marie_prefetch_fifo #(
        .W     (DW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({mem_rdata, r_mem_addr}),
        .i_pop   (w_pop),
        .i_flush (redir_vld),
        .o_count (w_count),
        .o_vld   (instr_vld),
        .o_head  (w_head)
    );

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_data  = w_head[DW+AW-1:AW];
    assign instr_addr  = w_head[AW-1:0];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_marie_fetch_unit.sv
// Bench for marie_fetch_unit: transaction-level model (word queue plus one
// outstanding request) compared every cycle, directed scenarios, random soak.
module tb_marie_fetch_unit;
    import marie_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_req;
    logic [7:0]   mem_addr;
    logic         mem_ack = 1'b0;
    logic [15:0]  mem_rdata = '0;
    logic         instr_vld;
    logic         instr_rdy = 1'b0;
    logic [15:0]  instr_data;
    logic [7:0]   instr_addr;
    logic         redir_vld = 1'b0;
    logic [7:0]   redir_addr = '0;
    fetch_state_t dbg_state;

    marie_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_vld   (instr_vld),
        .instr_rdy   (instr_rdy),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .redir_vld   (redir_vld),
        .redir_addr  (redir_addr),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    localparam int DEPTH = 4;
    logic [23:0] exp_q[$];
    bit          m_out      = 1'b0;
    logic [7:0]  m_out_addr = 8'h00;
    bit          m_drop     = 1'b0;
    logic [7:0]  m_nxt      = 8'h00;

    function automatic void model_edge();
        int  size_before = exp_q.size();
        bit  was_idle    = !m_out;
        bit  done        = m_out && mem_ack;
        if (size_before > 0 && instr_rdy && !redir_vld) void'(exp_q.pop_front());
        if (done) begin
            m_out = 1'b0;
            if (!m_drop && !redir_vld) begin
                exp_q.push_back({mem_rdata, m_out_addr});
                m_nxt = m_out_addr + 8'd1;
            end
        end
        if (redir_vld) begin
            exp_q.delete();
            m_nxt = redir_addr;
            if (m_out) m_drop = 1'b1;
        end
        if (!m_out && (done ? (exp_q.size() < DEPTH) : (was_idle && (redir_vld || size_before < DEPTH)))) begin
            m_out      = 1'b1;
            m_out_addr = m_nxt;
            m_drop     = 1'b0;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                m_out  = 1'b0;
                m_drop = 1'b0;
                m_nxt  = 8'h00;
            end else begin
                model_edge();
            end
        end
    end

    // ---------------- compare process ----------------
    logic [23:0] dut_log[$];
    logic [7:0]  ack_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("mem_req", 32'(mem_req), 32'(m_out));
                if (m_out) chk("mem_addr", 32'(mem_addr), 32'(m_out_addr));
                chk("instr_vld", 32'(instr_vld), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    chk("instr_data", 32'(instr_data), 32'(exp_q[0][23:8]));
                    chk("instr_addr", 32'(instr_addr), 32'(exp_q[0][7:0]));
                end
                if (instr_vld && instr_rdy && !redir_vld) dut_log.push_back({instr_data, instr_addr});
            end
        end
    end

    // ---------------- memory responder / drivers ----------------
    int wait_cnt   = 0;
    int lat        = 1;
    bit rand_mode  = 1'b0;
    bit rdata_rand = 1'b0;
    bit stray_en   = 1'b0;

    task automatic drive_ack();
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_rand ? 16'($urandom) : ({8'h00, mem_addr} * 16'd3);
                ack_log.push_back(mem_addr);
                wait_cnt  = 0;
                if (rand_mode) lat = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (stray_en && $urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        drive_ack();
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        mem_ack  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        wait_cnt = 0;
    endtask

    task automatic wait_log(int n, string name);
        for (int i = 0; i < 60 && dut_log.size() < n; i++) tick();
        if (dut_log.size() < n) chk(name, 32'(dut_log.size()), 32'(n));
    endtask

    task automatic wait_acks(int n, string name);
        for (int i = 0; i < 60 && ack_log.size() < n; i++) tick();
        if (ack_log.size() < n) chk(name, 32'(ack_log.size()), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dbase;
        int abase;
        bool_dummy: begin end
        // reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_instr_vld", 32'(instr_vld), 32'h0);
        chk("rst_instr_data", 32'(instr_data), 32'h0);
        chk("rst_instr_addr", 32'(instr_addr), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // scenario 1: ack one cycle after each request, consumer always ready
        lat = 1;
        instr_rdy = 1'b1;
        @(posedge clk);
        #2;
        chk("t1_first_req", 32'(mem_req), 32'h1);
        chk("t1_first_addr", 32'(mem_addr), 32'h0);
        drive_ack();
        wait_log(3, "t1_timeout");
        chk("t1_word0", 32'(dut_log[0]), 32'h0000_00);
        chk("t1_word1", 32'(dut_log[1]), 32'h0003_01);
        chk("t1_word2", 32'(dut_log[2]), 32'h0006_02);

        // scenario 2: consumer stalled, immediate acks fill the buffer
        reset_dut();
        instr_rdy = 1'b0;
        lat = 0;
        abase = ack_log.size();
        repeat (15) tick();
        chk("t2_acks", 32'(ack_log.size() - abase), 32'd4);
        chk("t2_req_low", 32'(mem_req), 32'h0);
        chk("t2_head", 32'({instr_data, instr_addr}), 32'h0000_00);
        instr_rdy = 1'b1;
        tick();
        instr_rdy = 1'b0;
        abase = ack_log.size();
        repeat (10) tick();
        chk("t2_refill_acks", 32'(ack_log.size() - abase), 32'd1);
        chk("t2_refill_req_low", 32'(mem_req), 32'h0);

        // scenario 3: redirect while a slow request is outstanding
        lat = 3;
        instr_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req && !mem_ack && wait_cnt == 1) break;
        end
        redir_vld  = 1'b1;
        redir_addr = 8'h40;
        abase = ack_log.size();
        dbase = dut_log.size();
        tick();
        redir_vld = 1'b0;
        chk("t3_vld_dropped", 32'(instr_vld), 32'h0);
        chk("t3_req_held", 32'(mem_req), 32'h1);
        chk("t3_state_flush", 32'(dbg_state), 32'(FLUSH));
        wait_acks(abase + 2, "t3_ack_timeout");
        chk("t3_next_req_addr", 32'(ack_log[abase + 1]), 32'h40);
        wait_log(dbase + 1, "t3_log_timeout");
        chk("t3_first_word", 32'(dut_log[dbase]), 32'h00C0_40);

        // scenario 4: redirect coinciding with ack and pop
        lat = 0;
        instr_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_vld && mem_ack) break;
        end
        instr_rdy  = 1'b1;
        redir_vld  = 1'b1;
        redir_addr = 8'h80;
        abase = ack_log.size();
        dbase = dut_log.size();
        tick();
        redir_vld = 1'b0;
        chk("t4_vld_dropped", 32'(instr_vld), 32'h0);
        wait_acks(abase + 1, "t4_ack_timeout");
        chk("t4_resume_addr", 32'(ack_log[abase]), 32'h80);
        wait_log(dbase + 1, "t4_log_timeout");
        chk("t4_first_word", 32'(dut_log[dbase]), 32'h0180_80);

        // scenario 5: address wrap
        redir_vld  = 1'b1;
        redir_addr = 8'hFE;
        dbase = dut_log.size();
        tick();
        redir_vld = 1'b0;
        wait_log(dbase + 4, "t5_log_timeout");
        chk("t5_addr0", 32'(dut_log[dbase][7:0]), 32'hFE);
        chk("t5_addr1", 32'(dut_log[dbase + 1][7:0]), 32'hFF);
        chk("t5_addr2", 32'(dut_log[dbase + 2][7:0]), 32'h00);
        chk("t5_addr3", 32'(dut_log[dbase + 3][7:0]), 32'h01);
        chk("t5_data0", 32'(dut_log[dbase][23:8]), 32'h02FA);

        // scenario 6: reset in the middle of a transaction
        instr_rdy = 1'b0;
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_q.size() == 2 && mem_req && !mem_ack) break;
        end
        chk("t6_setup", 32'(exp_q.size()), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_req_drop", 32'(mem_req), 32'h0);
        chk("t6_vld_drop", 32'(instr_vld), 32'h0);
        mem_ack = 1'b0;
        @(posedge clk);
        #2;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        wait_cnt  = 0;
        @(posedge clk);
        #2;
        mem_ack = 1'b0;
        chk("t6_restart_req", 32'(mem_req), 32'h1);
        chk("t6_restart_addr", 32'(mem_addr), 32'h00);
        chk("t6_no_stray", 32'(instr_vld), 32'h0);
        lat = 1;
        instr_rdy = 1'b1;
        dbase = dut_log.size();
        wait_log(dbase + 1, "t6_log_timeout");
        chk("t6_first_word", 32'(dut_log[dbase]), 32'h0000_00);

        // random soak
        rand_mode  = 1'b1;
        rdata_rand = 1'b1;
        stray_en   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            instr_rdy  = ($urandom_range(0, 3) != 0);
            redir_vld  = ($urandom_range(0, 19) == 0);
            redir_addr = ($urandom_range(0, 3) == 0) ? 8'hFD + 8'($urandom_range(0, 3)) : 8'($urandom);
        end
        redir_vld = 1'b0;
        stray_en  = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
